// File: rtl/program_counter_unit_if.sv
// Control-unit <-> PC unit bundle: requests in, pc/next_pc/RAS status out.
// The master side is the control unit; the slave side is the PC unit.
interface program_counter_unit_if #(
  parameter int PC_WIDTH  = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic                stall;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_offset;
  logic                jump;
  logic [PC_WIDTH-1:0] jump_target;
  logic                call;
  logic                ret;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] next_pc;
  logic [CW-1:0]       ras_count;
  logic                ras_overflow;
  logic                ras_underflow;

  modport master (
    output stall, branch_taken, branch_offset,
    output jump, jump_target, call, ret,
    input  pc, next_pc, ras_count,
    input  ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, branch_taken, branch_offset,
    input  jump, jump_target, call, ret,
    output pc, next_pc, ras_count,
    output ras_overflow, ras_underflow
  );
endinterface

// File: rtl/program_counter_unit.sv
// Word-addressed PC with stall/branch/jump and call/ret, updating on falling clk.
// Define PC_RAS_EN to build the return-address stack; otherwise call=jump, ret=seq.
module program_counter_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  RAS_DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  program_counter_unit_if.slave  bus
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_inc;

  assign pc_inc      = pc_q + PC_WIDTH'(1);
  assign bus.pc      = pc_q;
  assign bus.next_pc = pc_d;

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]       sp_q, sp_d, sp_top;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                push;

  // sp points at the next free slot; when full it also points at the oldest
  assign sp_top = sp_q - PW'(1);

  always_comb begin
    pc_d  = pc_inc;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.ret) begin
      if (cnt_q != '0) begin
        pc_d  = ras_q[sp_top];
        sp_d  = sp_top;
        cnt_d = cnt_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (bus.call) begin
      pc_d = bus.jump_target;
      push = 1'b1;
      sp_d = sp_q + PW'(1);
      if (cnt_q == CW'(RAS_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (bus.jump) begin
      pc_d = bus.jump_target;
    end else if (bus.branch_taken) begin
      pc_d = pc_q + bus.branch_offset;
    end
    if (!rst_n) begin
      pc_d = RESET_VECTOR;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(negedge clk) begin
    if (rst_n && push) begin
      ras_q[sp_q] <= pc_inc;
    end
  end

  assign bus.ras_count     = cnt_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
`else
  always_comb begin
    pc_d = pc_inc;
    if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.ret) begin
      pc_d = pc_inc;
    end else if (bus.call || bus.jump) begin
      pc_d = bus.jump_target;
    end else if (bus.branch_taken) begin
      pc_d = pc_q + bus.branch_offset;
    end
    if (!rst_n) begin
      pc_d = RESET_VECTOR;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.ras_count     = '0;
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit; state moves on negedge, checks at posedge+1.
// RAS expectations switch on PC_RAS_EN to match the build under test.
module tb_program_counter_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  program_counter_unit_if #(.PC_WIDTH(32), .RAS_DEPTH(4)) bus ();

  program_counter_unit #(
    .PC_WIDTH     (32),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (32'h100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = '0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] t);
    idle();
    bus.jump        = 1'b1;
    bus.jump_target = t;
    cyc();
    idle();
  endtask

  task automatic do_call(input logic [31:0] t);
    idle();
    bus.call        = 1'b1;
    bus.jump_target = t;
    cyc();
    idle();
  endtask

  task automatic do_ret();
    idle();
    bus.ret = 1'b1;
    cyc();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_pc", bus.pc, 32'h100);
    chk("rst_cnt", 32'(bus.ras_count), 32'd0);
    chk("rst_ovf", 32'(bus.ras_overflow), 32'd0);
    chk("rst_unf", 32'(bus.ras_underflow), 32'd0);

    rst_n = 1'b1;
    #1;
    chk("npc_seq", bus.next_pc, 32'h101);
    cyc();
    chk("seq1", bus.pc, 32'h101);
    cyc();
    chk("seq2", bus.pc, 32'h102);
    cyc();
    chk("seq3", bus.pc, 32'h103);

    jump_to(32'h10);
    chk("jump10", bus.pc, 32'h10);
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 32'hFFFF_FFFC;
    #1;
    chk("npc_br", bus.next_pc, 32'h0C);
    cyc();
    chk("br_neg", bus.pc, 32'h0C);

    bus.stall       = 1'b1;
    bus.jump        = 1'b1;
    bus.jump_target = 32'h55;
    #1;
    chk("npc_stall", bus.next_pc, 32'h0C);
    cyc();
    chk("stall1", bus.pc, 32'h0C);
    cyc();
    chk("stall2", bus.pc, 32'h0C);

    idle();
    bus.jump          = 1'b1;
    bus.jump_target   = 32'h20;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 32'h4;
    cyc();
    idle();
    chk("jmp_over_br", bus.pc, 32'h20);

    do_call(32'h80);
    chk("call_pc", bus.pc, 32'h80);
`ifdef PC_RAS_EN
    chk("call_cnt", 32'(bus.ras_count), 32'd1);
`else
    chk("call_cnt", 32'(bus.ras_count), 32'd0);
`endif
    cyc();
    cyc();
    chk("idle82", bus.pc, 32'h82);
    do_ret();
`ifdef PC_RAS_EN
    chk("ret_pc", bus.pc, 32'h21);
    chk("ret_cnt", 32'(bus.ras_count), 32'd0);

    jump_to(32'h1);
    do_call(32'h80);
    jump_to(32'h81);
    do_call(32'h80);
    jump_to(32'h82);
    do_call(32'h80);
    jump_to(32'h83);
    do_call(32'h80);
    chk("full_cnt", 32'(bus.ras_count), 32'd4);
    chk("full_ovf", 32'(bus.ras_overflow), 32'd0);
    jump_to(32'h84);
    do_call(32'h80);
    chk("ovf_cnt", 32'(bus.ras_count), 32'd4);
    chk("ovf_flag", 32'(bus.ras_overflow), 32'd1);
    do_ret();
    chk("pop1", bus.pc, 32'h85);
    do_ret();
    chk("pop2", bus.pc, 32'h84);
    do_ret();
    chk("pop3", bus.pc, 32'h83);
    do_ret();
    chk("pop4", bus.pc, 32'h82);
    chk("pop4_cnt", 32'(bus.ras_count), 32'd0);
    chk("pop4_unf", 32'(bus.ras_underflow), 32'd0);
    do_ret();
    chk("unf_pc", bus.pc, 32'h83);
    chk("unf_flag", 32'(bus.ras_underflow), 32'd1);
    chk("unf_cnt", 32'(bus.ras_count), 32'd0);
    chk("ovf_sticky", 32'(bus.ras_overflow), 32'd1);
`else
    chk("ret_pc", bus.pc, 32'h83);
    jump_to(32'h30);
    do_call(32'h40);
    chk("nr_call", bus.pc, 32'h40);
    do_ret();
    chk("nr_ret", bus.pc, 32'h41);
    chk("nr_ovf", 32'(bus.ras_overflow), 32'd0);
    chk("nr_unf", 32'(bus.ras_underflow), 32'd0);
`endif

    jump_to(32'h30);
    do_call(32'hFFFF_FFFF);
    chk("pc_max", bus.pc, 32'hFFFF_FFFF);
    cyc();
    chk("pc_wrap", bus.pc, 32'h0);
    do_call(32'h70);
    chk("call70", bus.pc, 32'h70);
`ifdef PC_RAS_EN
    chk("cnt2", 32'(bus.ras_count), 32'd2);
`endif
    bus.call        = 1'b1;
    bus.ret         = 1'b1;
    bus.jump_target = 32'h99;
    cyc();
    idle();
`ifdef PC_RAS_EN
    chk("callret_pc", bus.pc, 32'h1);
    chk("callret_cnt", 32'(bus.ras_count), 32'd1);
    do_call(32'h200);
    do_call(32'h300);
    chk("cnt3", 32'(bus.ras_count), 32'd3);
`else
    chk("callret_pc", bus.pc, 32'h71);
`endif

    rst_n     = 1'b0;
    bus.stall = 1'b1;
    bus.call  = 1'b1;
    cyc();
    chk("mid_rst_pc", bus.pc, 32'h100);
    chk("mid_rst_cnt", 32'(bus.ras_count), 32'd0);
    chk("mid_rst_ovf", 32'(bus.ras_overflow), 32'd0);
    chk("mid_rst_unf", 32'(bus.ras_underflow), 32'd0);
    idle();
    rst_n = 1'b1;
    cyc();
    chk("post_rst", bus.pc, 32'h101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
- Parametrised next-generation program counter for the soft processor. It merges the PC register and next-PC selection into one block.
- Adds stall, absolute jump, call/return with a return-address stack (RAS), a configurable reset vector and error flags.
- Sits between the control unit (branch/jump/call/ret decode) and instruction memory address input. Word-addressed: sequential step is +1.

Parameters:
- PC_WIDTH, 32, width of PC, offsets and targets
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
- RESET_VECTOR, 0, PC value loaded on reset

Ports:
- clk  input  1  system clock; all state updates on falling edge
- rst_n  input  1  synchronous active-low reset, sampled on falling edge of clk
- stall  input  1  hold PC and RAS unchanged
- branch_taken  input  1  relative branch request
- branch_offset  input  PC_WIDTH  signed two's-complement offset added to current pc
- jump  input  1  absolute jump request
- jump_target  input  PC_WIDTH  absolute target for jump/call
- call  input  1  jump to jump_target and push pc+1
- ret  input  1  pop RAS into pc
- pc  output  PC_WIDTH  current instruction address
- next_pc  output  PC_WIDTH  combinational value pc will take at next falling edge
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_overflow  output  1  sticky: push when full occurred
- ras_underflow  output  1  sticky: pop when empty occurred

Behaviour:
- Reset (rst_n=0 at falling edge): pc=RESET_VECTOR, ras_count=0, stack pointer=0, both sticky flags=0. Reset overrides stall and all requests, including mid-call/ret.
- Update: one falling edge per instruction; zero-latency next_pc, pc registers it at the edge.
- Priority, highest first: stall > ret > call > jump > branch_taken > sequential.
- stall=1: next_pc=pc, no RAS change, flags unchanged.
- ret: if ras_count>0, next_pc=top entry, pointer decrements, count-1. If empty, next_pc=pc+1, ras_underflow set, count stays 0.
- call: next_pc=jump_target; push pc+1. If count<RAS_DEPTH, count+1. If full, the circular buffer overwrites the oldest entry, count stays RAS_DEPTH, and ras_overflow is set.
- jump: next_pc=jump_target.
- branch_taken: next_pc=pc+branch_offset.
- Otherwise: next_pc=pc+1.
- Arithmetic: all additions modulo 2^PC_WIDTH; wrap-around is silent, no flag. pc=all-ones +1 gives 0.
- Simultaneous call+ret: ret wins, no push; count decrements by one only.
- Simultaneous jump+branch_taken: jump wins.
- Sticky flags clear only on reset.
- RAS pointer wraps modulo RAS_DEPTH.

Optional Feature:
- Macro PC_RAS_EN.
- Defined: RAS, ras_count and sticky flags operate as above.
- Undefined: no stack storage. call behaves as jump to jump_target, ret behaves as sequential (pc+1). ras_count, ras_overflow and ras_underflow are tied to 0.
- Priority order is otherwise unchanged.

Test Plan:
- Reset with RESET_VECTOR=0x100, then 3 idle edges -> pc 0x100, 0x101, 0x102, 0x103; flags 0.
- At pc=0x10, branch_taken with offset 0xFFFFFFFC (-4) -> pc=0x0C. Then stall high 2 edges -> pc holds 0x0C.
- At pc=0x20, call target 0x80 -> pc=0x80, ras_count=1. Two idle edges, then ret -> pc=0x21, ras_count=0.
- RAS_DEPTH=4: five calls from pc=0x1,0x81,0x82,0x83,0x84 (target 0x80 each) -> ras_overflow=1, count=4. Then 4 rets -> pc 0x85,0x84,0x83,0x82. A fifth ret -> underflow=1, pc=0x83.
- pc=0xFFFFFFFF idle edge -> pc=0. Same edge with call+ret asserted on a non-empty stack -> ret taken, count-1.
- Assert rst_n=0 mid-sequence with stall=1 and count=3 -> pc=RESET_VECTOR, count=0, flags cleared. Rebuild with PC_RAS_EN undefined: call 0x40 then ret -> pc 0x40 then 0x41.
